hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameters SHALL be MULT_CYC, default 5, mult/multu busy cycles; DIV_CYC, default 10, div/divu busy cycles.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 D_A1, D_A2  in  5 each  rs/rt register numbers of the D-stage instruction.
REQ-005 D_A1use, D_A2use  in  1 each  D-stage instruction reads rs/rt.
REQ-006 D_Tuse1, D_Tuse2  in  2 each  cycles until rs/rt value is consumed (0 = in D).
REQ-007 D_Is_MD  in  1  D-stage instruction uses the HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-008 E_A3, M_A3, W_A3  in  5 each  destination registers of E/M/W stages.
REQ-009 E_Reg_Write, M_Reg_Write, W_Reg_Write  in  1 each  stage writes GRF.
REQ-010 E_Tnew, M_Tnew  in  4 each  cycles until the stage's result is produced.
REQ-011 E_A1, E_A2  in  5 each; E_A1use, E_A2use  in  1 each  E-stage operand info.
REQ-012 E_MD_start  in  1  E stage holds mult/multu (E_MD_div=0) or div/divu (E_MD_div=1) this cycle.
REQ-013 E_MD_div  in  1  selects DIV_CYC when E_MD_start=1.
REQ-014 F_PC_WE, F_D_RegWE  out  1 each  PC and F/D register write enables.
REQ-015 D_E_clear  out  1  bubble insert into D/E register.
REQ-016 D_Fwd1, D_Fwd2  out  2 each  D operand source: 00 GRF, 01 M, 10 W.
REQ-017 E_Fwd1, E_Fwd2  out  2 each  E operand source: 00 pipe reg, 01 M, 10 W.
REQ-018 MD_busy  out  1  HI/LO unit busy.
REQ-019 stall_cnt  out  32  total stall cycles since reset.

Function
REQ-020 A stage X SHALL match operand k only if X_Reg_Write=1, X_A3!=0, X_A3==A_k, and the consumer's Ak use=1.
REQ-021 Data stall SHALL be asserted when, for either D operand, an E match has E_Tnew > D_Tuse or an M match has M_Tnew > D_Tuse.
REQ-022 Forwarding priority SHALL be nearest stage first: M over W; E-stage results are never forwarded.
REQ-023 D_Fwd SHALL select M only on an M match with M_Tnew==0, else W on a W match, else 00.
REQ-024 E_Fwd SHALL select M only on an M match with M_Tnew==0, else W on a W match, else 00.
REQ-025 Internal 4-bit md_cnt SHALL load MULT_CYC or DIV_CYC on the edge where E_MD_start=1, otherwise decrement toward 0 and hold at 0.
REQ-026 MD_busy SHALL equal (md_cnt!=0) | E_MD_start, combinationally.
REQ-027 MD stall SHALL be asserted when D_Is_MD=1 and MD_busy=1.
REQ-028 stall = data stall | MD stall; F_PC_WE=F_D_RegWE=!stall; D_E_clear=stall, all combinational in the same cycle.
REQ-029 E_MD_start while md_cnt!=0 SHALL reload the counter; stall logic is responsible for preventing this in legal streams.
REQ-030 stall_cnt SHALL increment by 1 on each edge with stall=1 and saturate at 32'hFFFF_FFFF.

Reset
REQ-031 On a reset edge md_cnt SHALL become 0 and stall_cnt 0; reset takes priority over E_MD_start and stall in the same cycle.
REQ-032 Combinational outputs SHALL follow inputs during reset; with all Reg_Write=0 and E_MD_start=0, F_PC_WE=F_D_RegWE=1 and D_E_clear=0.

Verification
REQ-033 Load-use: E_Reg_Write=1, E_A3=8, E_Tnew=1; D_A1=8, D_A1use=1, D_Tuse1=0 -> D_E_clear=1, F_PC_WE=0, stall_cnt +1 per cycle.
REQ-034 Write to $0: the same stimulus with E_A3=0 -> no stall; D_Fwd1=00.
REQ-035 Priority: M_A3=W_A3=9, both writing, M_Tnew=0, E_A2=9, E_A2use=1 -> E_Fwd2=01; M_Reg_Write=0 -> E_Fwd2=10.
REQ-036 Divide: pulse E_MD_start=1 with E_MD_div=1 for one cycle, then hold D_Is_MD=1 -> MD_busy=1 and stall for exactly 10 cycles after the pulse edge, then release.
REQ-037 Reset mid-multiply: reset 2 cycles after a mult start -> MD_busy=0 and stall_cnt=0 on the next cycle.
REQ-038 Saturation: preload stall_cnt near max via a forced stall -> counter holds at 32'hFFFF_FFFF with no wrap.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: per-operand match/forward lanes, HI/LO busy tracking,
// and stall generation with a saturating stall-cycle counter.
module hazard_operand #(
    parameter bit CHK_STALL = 1'b1
) (
    input  logic [4:0] a,
    input  logic       a_use,
    input  logic [1:0] tuse,
    input  logic [4:0] e_a3,
    input  logic       e_we,
    input  logic [3:0] e_tnew,
    input  logic [4:0] m_a3,
    input  logic       m_we,
    input  logic [3:0] m_tnew,
    input  logic [4:0] w_a3,
    input  logic       w_we,
    output logic       stall,
    output logic [1:0] fwd
);
    logic e_hit, m_hit, w_hit;

    assign e_hit = e_we && (e_a3 != 5'd0) && (e_a3 == a) && a_use;
    assign m_hit = m_we && (m_a3 != 5'd0) && (m_a3 == a) && a_use;
    assign w_hit = w_we && (w_a3 != 5'd0) && (w_a3 == a) && a_use;

    // E results are never forwarded; they can only force a stall.
    assign stall = CHK_STALL && ((e_hit && (e_tnew > {2'b00, tuse})) ||
                                 (m_hit && (m_tnew > {2'b00, tuse})));

    always_comb begin
        fwd = 2'b00;
        if (m_hit && (m_tnew == 4'd0)) fwd = 2'b01;
        else if (w_hit)                fwd = 2'b10;
    end
endmodule

module hazard_unit #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    input  logic        D_A1use,
    input  logic        D_A2use,
    input  logic [1:0]  D_Tuse1,
    input  logic [1:0]  D_Tuse2,
    input  logic        D_Is_MD,
    input  logic [4:0]  E_A3,
    input  logic [4:0]  M_A3,
    input  logic [4:0]  W_A3,
    input  logic        E_Reg_Write,
    input  logic        M_Reg_Write,
    input  logic        W_Reg_Write,
    input  logic [3:0]  E_Tnew,
    input  logic [3:0]  M_Tnew,
    input  logic [4:0]  E_A1,
    input  logic [4:0]  E_A2,
    input  logic        E_A1use,
    input  logic        E_A2use,
    input  logic        E_MD_start,
    input  logic        E_MD_div,
    output logic        F_PC_WE,
    output logic        F_D_RegWE,
    output logic        D_E_clear,
    output logic [1:0]  D_Fwd1,
    output logic [1:0]  D_Fwd2,
    output logic [1:0]  E_Fwd1,
    output logic [1:0]  E_Fwd2,
    output logic        MD_busy,
    output logic [31:0] stall_cnt
);
    localparam int NUM_OPS = 4;
    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    // Lanes 0/1 are the D operands, 2/3 the E operands.
    logic [NUM_OPS-1:0][4:0] op_a;
    logic [NUM_OPS-1:0]      op_use;
    logic [NUM_OPS-1:0][1:0] op_tuse;
    logic [NUM_OPS-1:0][1:0] op_fwd;
    logic [NUM_OPS-1:0]      op_stall;

    assign op_a    = {E_A2, E_A1, D_A2, D_A1};
    assign op_use  = {E_A2use, E_A1use, D_A2use, D_A1use};
    assign op_tuse = {2'b00, 2'b00, D_Tuse2, D_Tuse1};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        hazard_operand #(.CHK_STALL(i < 2)) u_op (
            .a      (op_a[i]),
            .a_use  (op_use[i]),
            .tuse   (op_tuse[i]),
            .e_a3   (E_A3),
            .e_we   (E_Reg_Write),
            .e_tnew (E_Tnew),
            .m_a3   (M_A3),
            .m_we   (M_Reg_Write),
            .m_tnew (M_Tnew),
            .w_a3   (W_A3),
            .w_we   (W_Reg_Write),
            .stall  (op_stall[i]),
            .fwd    (op_fwd[i])
        );
    end

    assign D_Fwd1 = op_fwd[0];
    assign D_Fwd2 = op_fwd[1];
    assign E_Fwd1 = op_fwd[2];
    assign E_Fwd2 = op_fwd[3];

    logic [3:0] md_cnt;
    logic       stall;

    assign MD_busy   = (md_cnt != 4'd0) | E_MD_start;
    assign stall     = (|op_stall) | (D_Is_MD & MD_busy);
    assign F_PC_WE   = ~stall;
    assign F_D_RegWE = ~stall;
    assign D_E_clear = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt    <= 4'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (E_MD_start)          md_cnt <= E_MD_div ? DIV_LD : MULT_LD;
            else if (md_cnt != 4'd0) md_cnt <= md_cnt - 4'd1;
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a cycle-indexed reference model.
module tb_hazard_unit;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_A1, D_A2, E_A3, M_A3, W_A3, E_A1, E_A2;
    logic        D_A1use, D_A2use, D_Is_MD;
    logic [1:0]  D_Tuse1, D_Tuse2;
    logic        E_Reg_Write, M_Reg_Write, W_Reg_Write;
    logic [3:0]  E_Tnew, M_Tnew;
    logic        E_A1use, E_A2use, E_MD_start, E_MD_div;
    logic        F_PC_WE, F_D_RegWE, D_E_clear, MD_busy;
    logic [1:0]  D_Fwd1, D_Fwd2, E_Fwd1, E_Fwd2;
    logic [31:0] stall_cnt;

    hazard_unit #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset),
        .D_A1(D_A1), .D_A2(D_A2), .D_A1use(D_A1use), .D_A2use(D_A2use),
        .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2), .D_Is_MD(D_Is_MD),
        .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
        .E_Reg_Write(E_Reg_Write), .M_Reg_Write(M_Reg_Write), .W_Reg_Write(W_Reg_Write),
        .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
        .E_A1(E_A1), .E_A2(E_A2), .E_A1use(E_A1use), .E_A2use(E_A2use),
        .E_MD_start(E_MD_start), .E_MD_div(E_MD_div),
        .F_PC_WE(F_PC_WE), .F_D_RegWE(F_D_RegWE), .D_E_clear(D_E_clear),
        .D_Fwd1(D_Fwd1), .D_Fwd2(D_Fwd2), .E_Fwd1(E_Fwd1), .E_Fwd2(E_Fwd2),
        .MD_busy(MD_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Reference state: cycle index, cycle at which HI/LO frees up, stall tally.
    longint cyc = 0;
    longint md_free_at = 0;
    longint ref_cnt = 0;

    function automatic bit hit(input bit we, input logic [4:0] a3, input logic [4:0] a, input bit u);
        return we && (a3 != 0) && (a3 == a) && u;
    endfunction

    function automatic bit ref_busy();
        return E_MD_start || (cyc < md_free_at);
    endfunction

    function automatic bit op_stall(input logic [4:0] a, input bit u, input int tuse);
        return (hit(E_Reg_Write, E_A3, a, u) && int'(E_Tnew) > tuse) ||
               (hit(M_Reg_Write, M_A3, a, u) && int'(M_Tnew) > tuse);
    endfunction

    function automatic logic [1:0] op_fwd(input logic [4:0] a, input bit u);
        if (hit(M_Reg_Write, M_A3, a, u) && M_Tnew == 0) return 2'b01;
        if (hit(W_Reg_Write, W_A3, a, u)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_stall();
        return op_stall(D_A1, D_A1use, int'(D_Tuse1)) || op_stall(D_A2, D_A2use, int'(D_Tuse2)) ||
               (D_Is_MD && ref_busy());
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit st;
        st = ref_stall();
        chk({tag, ".pc_we"},  32'(F_PC_WE),   32'(!st));
        chk({tag, ".fd_we"},  32'(F_D_RegWE), 32'(!st));
        chk({tag, ".clear"},  32'(D_E_clear), 32'(st));
        chk({tag, ".dfwd1"},  32'(D_Fwd1),    32'(op_fwd(D_A1, D_A1use)));
        chk({tag, ".dfwd2"},  32'(D_Fwd2),    32'(op_fwd(D_A2, D_A2use)));
        chk({tag, ".efwd1"},  32'(E_Fwd1),    32'(op_fwd(E_A1, E_A1use)));
        chk({tag, ".efwd2"},  32'(E_Fwd2),    32'(op_fwd(E_A2, E_A2use)));
        chk({tag, ".busy"},   32'(MD_busy),   32'(ref_busy()));
        chk({tag, ".scnt"},   stall_cnt,      32'(ref_cnt));
    endtask

    // Advance one clock edge and update the reference model from the pre-edge inputs.
    task automatic tick();
        bit st;
        st = ref_stall();
        @(posedge clk);
        if (reset) begin
            ref_cnt = 0;
            md_free_at = 0;
        end else begin
            if (st && ref_cnt < 64'hFFFF_FFFF) ref_cnt++;
            if (E_MD_start) md_free_at = cyc + 1 + (E_MD_div ? DIV_CYC : MULT_CYC);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        {D_A1, D_A2, E_A3, M_A3, W_A3, E_A1, E_A2} = '0;
        {D_A1use, D_A2use, D_Is_MD, E_Reg_Write, M_Reg_Write, W_Reg_Write} = '0;
        {D_Tuse1, D_Tuse2, E_Tnew, M_Tnew} = '0;
        {E_A1use, E_A2use, E_MD_start, E_MD_div} = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        #1 check_all("rst_comb");
        chk("rst_pc_we", 32'(F_PC_WE), 32'd1);
        chk("rst_clear", 32'(D_E_clear), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1 check_all("rst_done");
        chk("rst_scnt", stall_cnt, 32'd0);

        // Load-use: one bubble per cycle while the producer sits in E.
        E_Reg_Write = 1; E_A3 = 8; E_Tnew = 1; D_A1 = 8; D_A1use = 1; D_Tuse1 = 0;
        #1 check_all("lu0");
        chk("lu_clear", 32'(D_E_clear), 32'd1);
        chk("lu_pc_we", 32'(F_PC_WE), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            #1 check_all("lu");
            chk("lu_scnt", stall_cnt, 32'(i));
        end

        // Writes to $0 never hazard or forward.
        E_A3 = 0; M_Reg_Write = 1; M_A3 = 0; M_Tnew = 0;
        #1 check_all("r0");
        chk("r0_clear", 32'(D_E_clear), 32'd0);
        chk("r0_dfwd1", 32'(D_Fwd1), 32'd0);
        tick();

        // M beats W; with M quiet the W copy is used.
        idle_inputs();
        M_A3 = 9; W_A3 = 9; M_Reg_Write = 1; W_Reg_Write = 1; M_Tnew = 0; E_A2 = 9; E_A2use = 1;
        #1 check_all("pri_m");
        chk("pri_m_efwd2", 32'(E_Fwd2), 32'd1);
        M_Reg_Write = 0;
        #1 check_all("pri_w");
        chk("pri_w_efwd2", 32'(E_Fwd2), 32'd2);
        M_Reg_Write = 1; M_Tnew = 2;
        #1 check_all("pri_mlate");
        tick();

        // Divide: busy for exactly DIV_CYC cycles after the start edge.
        idle_inputs();
        E_MD_start = 1; E_MD_div = 1;
        #1 check_all("div_pulse");
        tick();
        E_MD_start = 0; E_MD_div = 0; D_Is_MD = 1;
        for (int i = 0; i < DIV_CYC + 2; i++) begin
            #1 check_all("div");
            chk("div_busy", 32'(MD_busy), 32'(i < DIV_CYC));
            chk("div_stall", 32'(D_E_clear), 32'(i < DIV_CYC));
            tick();
        end

        // Reset two cycles into a multiply clears busy and the tally.
        idle_inputs();
        E_MD_start = 1;
        tick();
        E_MD_start = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        #1 check_all("rst_mult");
        chk("rst_mult_busy", 32'(MD_busy), 32'd0);
        chk("rst_mult_scnt", stall_cnt, 32'd0);

        // Saturation: preload the tally just below max, then keep stalling.
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt;
        ref_cnt = 64'hFFFF_FFFD;
        E_Reg_Write = 1; E_A3 = 8; E_Tnew = 1; D_A1 = 8; D_A1use = 1; D_Tuse1 = 0;
        #1 check_all("sat0");
        for (int i = 0; i < 4; i++) begin
            tick();
            #1 check_all("sat");
        end
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);

        // Randomized traffic over a small register window to provoke matches.
        reset = 1;
        idle_inputs();
        tick();
        reset = 0;
        for (int i = 0; i < 400; i++) begin
            D_A1 = 5'($urandom_range(0, 3)); D_A2 = 5'($urandom_range(0, 3));
            E_A1 = 5'($urandom_range(0, 3)); E_A2 = 5'($urandom_range(0, 3));
            E_A3 = 5'($urandom_range(0, 3)); M_A3 = 5'($urandom_range(0, 3));
            W_A3 = 5'($urandom_range(0, 3));
            D_A1use = 1'($urandom); D_A2use = 1'($urandom);
            E_A1use = 1'($urandom); E_A2use = 1'($urandom);
            E_Reg_Write = 1'($urandom); M_Reg_Write = 1'($urandom); W_Reg_Write = 1'($urandom);
            D_Tuse1 = 2'($urandom_range(0, 2)); D_Tuse2 = 2'($urandom_range(0, 2));
            E_Tnew = 4'($urandom_range(0, 3)); M_Tnew = 4'($urandom_range(0, 2));
            D_Is_MD = ($urandom_range(0, 3) == 0);
            E_MD_start = ($urandom_range(0, 15) == 0);
            E_MD_div = 1'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            #1 check_all("rnd");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
